// File: rtl/fabm_pg_stage_if.sv
// Handshake bundle between the compression tree, the propagate/generate stage and
// the carry-chain adder. The slave side is the stage itself.
interface fabm_pg_stage_if #(
    parameter int W     = 64,
    parameter int SPLIT = 14
);
    // Valid/ready contract on both sides: a transfer happens on a rising edge where
    // valid and ready are both 1; a producer holding valid=1 without that transfer
    // keeps its data stable until it happens.
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         row_a;
    logic [W-1:0]         row_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-SPLIT-1:0]   prop;
    logic [W-SPLIT-1:0]   gen;
    logic                 cin;
    logic [SPLIT-1:0]     product_lo;
    logic [1:0]           occ_dbg;

    modport master (
        output in_valid, row_a, row_b, out_ready,
        input  in_ready, out_valid, prop, gen, cin, product_lo, occ_dbg
    );

    modport slave (
        input  in_valid, row_a, row_b, out_ready,
        output in_ready, out_valid, prop, gen, cin, product_lo, occ_dbg
    );
endinterface

// File: rtl/fabm_pg_stage.sv
// Registered propagate/generate stage feeding the upper-bit carry chain, with the low
// product bits resolved here and a 2-entry skid buffer on the handshake.
module fabm_pg_stage #(
    parameter int W         = 64,
    parameter int SPLIT     = 14,
    parameter int APPROX_LO = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    fabm_pg_stage_if.slave  bus
);
    localparam int PW = W - SPLIT;
    localparam int EW = 2 * PW + 1 + SPLIT;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]       occ_d, occ_q;
    logic [EW-1:0]    head_d, head_q;
    logic [EW-1:0]    skid_d, skid_q;
    logic [EW-1:0]    in_ent;
    logic [SPLIT-1:0] lo_in;
    logic             cin_in;
    logic [PW-1:0]    a_hi, b_hi;
    logic             in_ready_w, out_valid_w;
    logic             push, pop;

    assign a_hi = bus.row_a[W-1:SPLIT];
    assign b_hi = bus.row_b[W-1:SPLIT];

    generate
        if (APPROX_LO != 0) begin : g_approx
            // OR-approximation: only the top truncated column contributes a carry.
            always_comb begin
                lo_in  = bus.row_a[SPLIT-1:0] | bus.row_b[SPLIT-1:0];
                cin_in = bus.row_a[SPLIT-1] & bus.row_b[SPLIT-1];
            end
        end else begin : g_exact
            always_comb begin
                {cin_in, lo_in} = {1'b0, bus.row_a[SPLIT-1:0]} + {1'b0, bus.row_b[SPLIT-1:0]};
            end
        end
    endgenerate

    assign in_ent = {a_hi ^ b_hi, a_hi, cin_in, lo_in};

    assign in_ready_w  = (occ_q != OCC_FULL);
    assign out_valid_w = (occ_q != OCC_EMPTY);
    assign push        = bus.in_valid & in_ready_w;
    assign pop         = out_valid_w & bus.out_ready;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    occ_d  = OCC_ONE;
                    head_d = in_ent;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = in_ent;
                end else if (push) begin
                    occ_d  = OCC_FULL;
                    skid_d = in_ent;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    occ_d  = OCC_ONE;
                    head_d = skid_q;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.prop       = head_q[EW-1 -: PW];
    assign bus.gen        = head_q[EW-PW-1 -: PW];
    assign bus.cin        = head_q[SPLIT];
    assign bus.product_lo = head_q[SPLIT-1:0];
    assign bus.occ_dbg    = occ_q;
endmodule

// File: tb/tb_fabm_pg_stage.sv
// Drives identical traffic into an approximate and an exact instance and checks both
// against a queue-level model and an arithmetic golden product.
module tb_fabm_pg_stage;
    localparam int W     = 64;
    localparam int SPLIT = 14;
    localparam int PW    = W - SPLIT;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] row_a;
    logic [W-1:0] row_b;

    fabm_pg_stage_if #(.W(W), .SPLIT(SPLIT)) if_apx ();
    fabm_pg_stage_if #(.W(W), .SPLIT(SPLIT)) if_ex ();

    assign if_apx.in_valid  = in_valid;
    assign if_apx.out_ready = out_ready;
    assign if_apx.row_a     = row_a;
    assign if_apx.row_b     = row_b;
    assign if_ex.in_valid   = in_valid;
    assign if_ex.out_ready  = out_ready;
    assign if_ex.row_a      = row_a;
    assign if_ex.row_b      = row_b;

    fabm_pg_stage #(.W(W), .SPLIT(SPLIT), .APPROX_LO(1)) u_apx (
        .clk(clk), .rst_n(rst_n), .bus(if_apx.slave)
    );
    fabm_pg_stage #(.W(W), .SPLIT(SPLIT), .APPROX_LO(0)) u_ex (
        .clk(clk), .rst_n(rst_n), .bus(if_ex.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];
    logic last_push = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Full product the downstream chain must produce for a given row pair.
    function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input bit approx);
        logic [W-1:0] hi;
        logic [W-1:0] mask;
        if (!approx) return a + b;
        mask = (64'd1 << SPLIT) - 64'd1;
        hi = (a >> SPLIT) + (b >> SPLIT) + {63'd0, a[SPLIT-1] & b[SPLIT-1]};
        return (hi << SPLIT) | ((a | b) & mask);
    endfunction

    // CARRY4-style ripple: sum = S ^ c, carry-out = S ? c : DI.
    function automatic logic [W-1:0] chain(input logic [PW-1:0] p, input logic [PW-1:0] g,
                                           input logic c0, input logic [SPLIT-1:0] lo);
        logic c;
        logic [PW-1:0] s;
        c = c0;
        for (int i = 0; i < PW; i++) begin
            s[i] = p[i] ^ c;
            c    = p[i] ? c : g[i];
        end
        return {s, lo};
    endfunction

    function automatic logic [W-1:0] rnd64();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = v | 64'h3fff;
            2: v = v & 64'h3fff;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check_outputs();
        int sz;
        logic [W-1:0] a, b;
        sz = exp_q.size();
        chk("apx_in_ready", {63'd0, if_apx.in_ready}, {63'd0, sz != 2});
        chk("ex_in_ready", {63'd0, if_ex.in_ready}, {63'd0, sz != 2});
        chk("apx_out_valid", {63'd0, if_apx.out_valid}, {63'd0, sz != 0});
        chk("ex_out_valid", {63'd0, if_ex.out_valid}, {63'd0, sz != 0});
        if (sz != 0) begin
            a = exp_q[0][2*W-1:W];
            b = exp_q[0][W-1:0];
            chk("apx_prop", W'(if_apx.prop), (a ^ b) >> SPLIT);
            chk("apx_gen", W'(if_apx.gen), a >> SPLIT);
            chk("apx_product", chain(if_apx.prop, if_apx.gen, if_apx.cin, if_apx.product_lo),
                golden(a, b, 1'b1));
            chk("ex_prop", W'(if_ex.prop), (a ^ b) >> SPLIT);
            chk("ex_gen", W'(if_ex.gen), a >> SPLIT);
            chk("ex_product", chain(if_ex.prop, if_ex.gen, if_ex.cin, if_ex.product_lo),
                golden(a, b, 1'b0));
        end
    endtask

    // Called at a falling edge with inputs already driven; advances one clock.
    task automatic step();
        bit push, pop;
        check_outputs();
        push = in_valid && (exp_q.size() != 2);
        pop  = out_ready && (exp_q.size() != 0);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({row_a, row_b});
        last_push = push;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        row_a     = '0;
        row_b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, if_apx.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, if_apx.in_ready}, 64'd1);
        chk("rst_prop", W'(if_apx.prop), 64'd0);
        chk("rst_gen", W'(if_ex.gen), 64'd0);
        chk("rst_cin", {63'd0, if_ex.cin}, 64'd0);
        chk("rst_lo", W'(if_ex.product_lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Approximate low region with both top truncated bits set.
        row_a = 64'h2000; row_b = 64'h2000; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_out_valid", {63'd0, if_apx.out_valid}, 64'd1);
        chk("t2_apx_lo", W'(if_apx.product_lo), 64'h2000);
        chk("t2_apx_cin", {63'd0, if_apx.cin}, 64'd1);
        chk("t2_apx_prop", W'(if_apx.prop), 64'd0);
        chk("t2_apx_gen", W'(if_apx.gen), 64'd0);
        chk("t2_ex_lo", W'(if_ex.product_lo), 64'd0);
        chk("t2_ex_cin", {63'd0, if_ex.cin}, 64'd1);
        step();

        // Exact low region overflowing into the chain.
        row_a = 64'h1_3FFF; row_b = 64'h1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t3_ex_lo", W'(if_ex.product_lo), 64'd0);
        chk("t3_ex_cin", {63'd0, if_ex.cin}, 64'd1);
        chk("t3_ex_prop", W'(if_ex.prop), 64'd4);
        chk("t3_ex_gen", W'(if_ex.gen), 64'd4);
        chk("t3_apx_lo", W'(if_apx.product_lo), 64'h3fff);
        chk("t3_apx_cin", {63'd0, if_apx.cin}, 64'd0);
        step();

        // Backpressure: X, Y fill the buffer, Z must wait.
        out_ready = 1'b0; in_valid = 1'b1;
        row_a = 64'h0123_4567_89ab_cdef; row_b = 64'h1111_2222_3333_4444; step();
        row_a = 64'hffff_0000_ffff_0000; row_b = 64'h0000_ffff_0000_ffff; step();
        row_a = 64'hdead_beef_cafe_3fff; row_b = 64'h0000_0000_0000_3fff;
        chk("t4_in_ready_full", {63'd0, if_apx.in_ready}, 64'd0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !last_push; i++) step();
        chk("t4_z_accepted", {63'd0, last_push}, 64'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        chk("t4_drained", {63'd0, if_apx.out_valid}, 64'd0);

        // Asynchronous reset mid-cycle with the buffer full.
        out_ready = 1'b0; in_valid = 1'b1;
        row_a = rnd64(); row_b = rnd64(); step();
        row_a = rnd64(); row_b = rnd64(); step();
        in_valid = 1'b0;
        chk("t1_occ_full", W'(if_apx.occ_dbg), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_out_valid", {63'd0, if_apx.out_valid}, 64'd0);
        chk("t1_in_ready", {63'd0, if_ex.in_ready}, 64'd1);
        chk("t1_prop", W'(if_apx.prop), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate streaming.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            row_a = rnd64(); row_b = rnd64();
            chk("t5_in_ready", {63'd0, if_apx.in_ready}, 64'd1);
            step();
        end

        // Random valid/ready; a refused word is held until accepted.
        for (int i = 0; i < 10000; i++) begin
            if (!(in_valid && !last_push)) begin
                in_valid = 1'($urandom_range(0, 1));
                row_a = rnd64(); row_b = rnd64();
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("final_empty", {63'd0, if_ex.out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
